// File: rtl/alu_pkg.sv
// Shared ALU types: opcode encoding and the tagged response record.
// Used by the server, its result FIFO and any initiator or bench.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_t;

    // Tag width carried through the result FIFO; server ID_W must match.
    localparam int ALU_ID_W = 4;

    typedef struct packed {
        logic [ALU_ID_W-1:0] id;
        logic [63:0]         s;
        logic                cout;
        logic                zero;
        logic                ovf;
    } alu_resp_t;

endpackage

// File: rtl/alu64bit.sv
// Combinational 64-bit ALU core: NOR, XOR, ADD (a+b+cin), SUB (a+~b+cin).
// SUB with cin=1 yields a-b; cout is then the not-borrow.
module alu64bit
    import alu_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    input  alu_op_t     op,
    output logic [63:0] s,
    output logic        cout
);

    logic [64:0] sum_s;
    logic [63:0] b_eff_s;

    assign b_eff_s = (op == OP_SUB) ? ~b : b;
    assign sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {64'd0, cin};

    // Result and carry selection per opcode
    always_comb begin
        s    = 64'd0;
        cout = 1'b0;
        case (op)
            OP_NOR: s = ~(a | b);
            OP_XOR: s = a ^ b;
            OP_ADD, OP_SUB: begin
                s    = sum_s[63:0];
                cout = sum_s[64];
            end
            default: begin
                s    = 64'd0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_resp_fifo.sv
// DEPTH-entry synchronous FIFO of alu_resp_t with occupancy count.
// Head reads as all-zero while empty so response data is clean after reset.
module alu_resp_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  alu_resp_t              push_data_i,
    input  logic                   pop_i,
    output alu_resp_t              head_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    alu_resp_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             pop_s;

    assign valid_o = (count_q != {(PTR_W+1){1'b0}});
    assign pop_s   = pop_i & valid_o;
    assign count_o = count_q;
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    // Pointer and occupancy next-state
    always_comb begin
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_i, pop_s})
            2'b10:   count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are masked by valid_o so no reset is needed
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/alu64bit_server.sv
// Valid/ready transaction wrapper around alu64bit: one request register,
// flag generation, in-order result FIFO and an executed-operation counter.
module alu64bit_server
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = ALU_ID_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic             req_cin,
    input  alu_op_t          req_op,
    input  logic [ID_W-1:0]  req_id,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [63:0]      resp_s,
    output logic             resp_cout,
    output logic             resp_zero,
    output logic             resp_ovf,
    output logic [ID_W-1:0]  resp_id,
    output logic [CNT_W-1:0] op_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             s1_valid_q, s1_valid_d;
    logic [63:0]      s1_a_q, s1_a_d;
    logic [63:0]      s1_b_q, s1_b_d;
    logic             s1_cin_q, s1_cin_d;
    alu_op_t          s1_op_q, s1_op_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             accept_s;
    logic             pop_s;
    logic [63:0]      alu_s_s;
    logic             alu_cout_s;
    logic             ovf_s;
    logic             fifo_valid_s;
    logic [PTR_W:0]   fifo_count_s;
    alu_resp_t        push_data_s;
    alu_resp_t        head_s;

    // Credit rule: the stage-1 entry always has a reserved FIFO slot
    assign req_ready = ({1'b0, fifo_count_s} + {{(PTR_W+1){1'b0}}, s1_valid_q})
                       < (PTR_W+2)'(DEPTH);
    assign accept_s  = req_valid & req_ready;
    assign pop_s     = fifo_valid_s & resp_ready;

    alu64bit u_alu (
        .a    (s1_a_q),
        .b    (s1_b_q),
        .cin  (s1_cin_q),
        .op   (s1_op_q),
        .s    (alu_s_s),
        .cout (alu_cout_s)
    );

    // Signed overflow only meaningful for the arithmetic ops
    always_comb begin
        case (s1_op_q)
            OP_ADD:  ovf_s = (s1_a_q[63] == s1_b_q[63]) && (alu_s_s[63] != s1_a_q[63]);
            OP_SUB:  ovf_s = (s1_a_q[63] != s1_b_q[63]) && (alu_s_s[63] != s1_a_q[63]);
            default: ovf_s = 1'b0;
        endcase
    end

    assign push_data_s.id   = ALU_ID_W'(s1_id_q);
    assign push_data_s.s    = alu_s_s;
    assign push_data_s.cout = alu_cout_s;
    assign push_data_s.zero = (alu_s_s == 64'd0);
    assign push_data_s.ovf  = ovf_s;

    alu_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (s1_valid_q),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .valid_o     (fifo_valid_s),
        .count_o     (fifo_count_s)
    );

    // Stage-1 load and counter next-state
    always_comb begin
        s1_valid_d = accept_s;
        if (accept_s) begin
            s1_a_d   = req_a;
            s1_b_d   = req_b;
            s1_cin_d = req_cin;
            s1_op_d  = req_op;
            s1_id_d  = req_id;
        end else begin
            s1_a_d   = s1_a_q;
            s1_b_d   = s1_b_q;
            s1_cin_d = s1_cin_q;
            s1_op_d  = s1_op_q;
            s1_id_d  = s1_id_q;
        end
        op_count_d = op_count_q + CNT_W'(s1_valid_q);
    end

    // Stage-1 and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= 64'd0;
            s1_b_q     <= 64'd0;
            s1_cin_q   <= 1'b0;
            s1_op_q    <= OP_NOR;
            s1_id_q    <= {ID_W{1'b0}};
            op_count_q <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_cin_q   <= s1_cin_d;
            s1_op_q    <= s1_op_d;
            s1_id_q    <= s1_id_d;
            op_count_q <= op_count_d;
        end
    end

    assign resp_valid = fifo_valid_s;
    assign resp_s     = head_s.s;
    assign resp_cout  = head_s.cout;
    assign resp_zero  = head_s.zero;
    assign resp_ovf   = head_s.ovf;
    assign resp_id    = ID_W'(head_s.id);
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu64bit_server.sv
// Randomized bench for alu64bit_server against a queue-based transaction model.
module tb_alu64bit_server;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int ID_W  = 4;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [63:0]      req_a = 64'd0;
    logic [63:0]      req_b = 64'd0;
    logic             req_cin = 1'b0;
    alu_op_t          req_op = OP_NOR;
    logic [ID_W-1:0]  req_id = 4'd0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [63:0]      resp_s;
    logic             resp_cout;
    logic             resp_zero;
    logic             resp_ovf;
    logic [ID_W-1:0]  resp_id;
    logic [CNT_W-1:0] op_count;

    alu64bit_server #(.DEPTH(DEPTH), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_op(req_op), .req_id(req_id),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_s(resp_s), .resp_cout(resp_cout), .resp_zero(resp_zero),
        .resp_ovf(resp_ovf), .resp_id(resp_id), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Outstanding transactions: accepted but not yet consumed, in order.
    typedef struct {
        logic [63:0]     s;
        logic            cout;
        logic            zero;
        logic            ovf;
        logic [ID_W-1:0] id;
        int              vis;
    } exp_t;

    exp_t        mq[$];
    int          cyc = 0;
    logic [31:0] pushed_exp = 32'd0;
    bit          acc_prev = 1'b0;
    int          tests = 0;
    int          fails = 0;

    function automatic exp_t model(logic [63:0] a, logic [63:0] b, logic cin,
                                   alu_op_t op, logic [ID_W-1:0] id, int vis);
        exp_t        e;
        logic [64:0] w;
        e.cout = 1'b0;
        e.ovf  = 1'b0;
        e.id   = id;
        e.vis  = vis;
        case (op)
            OP_NOR: e.s = ~(a | b);
            OP_XOR: e.s = a ^ b;
            OP_ADD: begin
                w      = 65'(a) + 65'(b) + 65'(cin);
                e.s    = w[63:0];
                e.cout = w[64];
                e.ovf  = (a[63] == b[63]) && (e.s[63] != a[63]);
            end
            default: begin
                // a - b, minus one more when cin=0; carry = no borrow
                e.s    = a - b - 64'(!cin);
                e.cout = (65'(a) >= 65'(b) + 65'(!cin));
                e.ovf  = (a[63] != b[63]) && (e.s[63] != a[63]);
            end
        endcase
        e.zero = (e.s == 64'd0);
        return e;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        mq.delete();
        pushed_exp = 32'd0;
        acc_prev   = 1'b0;
    endtask

    // One clock: decide handshakes from pre-edge state, advance model, settle.
    task automatic tick(output bit acc);
        bit rdy, vld, pop;
        rdy = (mq.size() < DEPTH);
        vld = (mq.size() > 0) && (mq[0].vis <= cyc);
        acc = rst_n && req_valid && rdy;
        pop = rst_n && vld && resp_ready;
        @(posedge clk);
        if (rst_n) begin
            cyc++;
            if (acc_prev) pushed_exp++;
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(model(req_a, req_b, req_cin, req_op, req_id, cyc + 1));
            acc_prev = acc;
        end else begin
            clear_model();
        end
        #1;
    endtask

    task automatic drive(logic [63:0] a, logic [63:0] b, logic cin, alu_op_t op, logic [ID_W-1:0] id);
        req_valid = 1'b1;
        req_a = a; req_b = b; req_cin = cin; req_op = op; req_id = id;
    endtask

    function automatic logic [63:0] pick_operand();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'd0;
            1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            3:       v = 64'h8000_0000_0000_0000;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic drive_random(logic [ID_W-1:0] id);
        drive(pick_operand(), pick_operand(), 1'($urandom), alu_op_t'(2'($urandom)), id);
    endtask

    // Single compare process against the model on every falling edge
    always @(negedge clk) begin
        bit ve;
        ve = (mq.size() > 0) && (mq[0].vis <= cyc);
        chk("req_ready", 64'(req_ready), 64'(mq.size() < DEPTH));
        chk("resp_valid", 64'(resp_valid), 64'(ve));
        chk("op_count", 64'(op_count), 64'(pushed_exp));
        if (ve) begin
            chk("resp_s", resp_s, mq[0].s);
            chk("resp_cout", 64'(resp_cout), 64'(mq[0].cout));
            chk("resp_zero", 64'(resp_zero), 64'(mq[0].zero));
            chk("resp_ovf", 64'(resp_ovf), 64'(mq[0].ovf));
            chk("resp_id", 64'(resp_id), 64'(mq[0].id));
        end
    end

    initial begin
        bit a;
        int j, nacc, budget;

        // 1: reset held with a request offered
        rst_n = 1'b0;
        drive(64'd5, 64'd6, 1'b0, OP_ADD, 4'd9);
        repeat (3) tick(a);
        chk("t1_ready", 64'(req_ready), 64'd1);
        chk("t1_valid", 64'(resp_valid), 64'd0);
        chk("t1_count", 64'(op_count), 64'd0);
        rst_n = 1'b1;

        // 2: single ADD
        resp_ready = 1'b1;
        drive(64'd1, 64'd1, 1'b0, OP_ADD, 4'd3);
        tick(a);
        chk("t2_accept", 64'(a), 64'd1);
        req_valid = 1'b0;
        tick(a);
        chk("t2_valid", 64'(resp_valid), 64'd1);
        chk("t2_s", resp_s, 64'd2);
        chk("t2_flags", {61'd0, resp_cout, resp_zero, resp_ovf}, 64'd0);
        chk("t2_id", 64'(resp_id), 64'd3);
        chk("t2_count", 64'(op_count), 64'd1);

        // 3: signed overflow, then carry-out wrap to zero
        drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, OP_ADD, 4'd4);
        tick(a);
        req_valid = 1'b0;
        tick(a);
        chk("t3_ovf_s", resp_s, 64'h8000_0000_0000_0000);
        chk("t3_ovf_flags", {61'd0, resp_cout, resp_zero, resp_ovf}, 64'd1);
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, OP_ADD, 4'd5);
        tick(a);
        req_valid = 1'b0;
        tick(a);
        chk("t3_wrap_s", resp_s, 64'd0);
        chk("t3_wrap_flags", {61'd0, resp_cout, resp_zero, resp_ovf}, 64'd6);
        tick(a);

        // 4: backpressure, six requests offered with ids 0..5
        resp_ready = 1'b0;
        j = 0; nacc = 0;
        for (int c = 0; c < 6; c++) begin
            drive_random(4'(j));
            tick(a);
            if (a) begin j++; nacc++; end
        end
        chk("t4_accepted", 64'(nacc), 64'(DEPTH));
        chk("t4_ready_low", 64'(req_ready), 64'd0);
        chk("t4_head_id", 64'(resp_id), 64'd0);
        repeat (3) tick(a);
        resp_ready = 1'b1;
        budget = 0;
        while (j < 6 && budget < 30) begin
            drive_random(4'(j));
            tick(a);
            if (a) j++;
            budget++;
        end
        chk("t4_all_accepted", 64'(j), 64'd6);
        req_valid = 1'b0;
        budget = 0;
        while (mq.size() > 0 && budget < 20) begin
            tick(a);
            budget++;
        end
        chk("t4_drained", 64'(mq.size()), 64'd0);

        // 5: 100 back-to-back requests from a fresh reset
        rst_n = 1'b0;
        clear_model();
        tick(a);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        nacc = 0;
        for (int i = 0; i < 100; i++) begin
            drive_random(4'(i));
            tick(a);
            if (a) nacc++;
        end
        chk("t5_accepted", 64'(nacc), 64'd100);
        req_valid = 1'b0;
        repeat (3) tick(a);
        chk("t5_count", 64'(op_count), 64'd100);

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) drive_random(4'($urandom));
            else req_valid = 1'b0;
            resp_ready = ($urandom_range(0, 2) != 0);
            tick(a);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (8) tick(a);

        // 6: reset with three results queued
        resp_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 3; i++) begin
            drive_random(4'(i + 8));
            tick(a);
            if (a) nacc++;
        end
        req_valid = 1'b0;
        repeat (2) tick(a);
        chk("t6_queued", 64'(nacc), 64'd3);
        chk("t6_valid_before", 64'(resp_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("t6_valid_async", 64'(resp_valid), 64'd0);
        chk("t6_count_async", 64'(op_count), 64'd0);
        chk("t6_ready_async", 64'(req_ready), 64'd1);
        tick(a);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        repeat (6) tick(a);
        chk("t6_no_stale", 64'(resp_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
